mult_product_accumulator: RTL and testbench

//  Downstream stage of the 4x4 array multiplier. Consumes one 8-bit product per

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_sat_adder.sv | 24 ++
 rtl/mult_product_accumulator.sv | 112 +++++++++++
 tb/tb_mult_product_accumulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the 4x4 array multiplier and its downstream stages.
//   PROD_W_DEF   : default product width (8 bits for a 4x4 multiplier)
//   acc_state_e  : accumulator FSM state encoding
//   count_width  : width of a counter that must reach n inclusive
package mult_pkg;

  localparam int PROD_W_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Bits needed to hold the values 0..n. The result is never below 1, so a
  // counter port is never zero-width.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_sat_adder.sv
// Unsigned saturating adder: sum = min(a + zext(b), 2^ACC_W - 1).
//   a        in   ACC_W  running value
//   b        in   B_W    addend, zero-extended (B_W <= ACC_W)
//   sum      out  ACC_W  clamped sum
//   overflow out  1      the true sum did not fit in ACC_W bits
module mult_sat_adder #(
  parameter int ACC_W = 16,
  parameter int B_W   = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  // One extra bit catches the carry out. An unsigned add of an ACC_W-bit
  // value and a narrower value can overflow by at most one bit.
  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, a} + (ACC_W + 1)'(b);
  assign overflow = full_sum[ACC_W];
  assign sum      = overflow ? '1 : full_sum[ACC_W-1:0];

endmodule

// File: rtl/mult_product_accumulator.sv
// Sums BLOCK_LEN products into a saturating accumulator. The result is
// presented on a valid/ready port and held there until it is accepted.
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   prod_i         product from the multiplier
//   prod_valid_i   prod_i is valid this cycle
//   prod_ready_o   a product can be accepted this cycle (depends on state only)
//   clear_i        synchronous abort; discards the partial sum (highest priority)
//   acc_o          registered running sum, or the final sum while acc_valid_o
//   acc_valid_o    acc_o holds a completed block
//   acc_ready_i    consumer accepts acc_o
//   overflow_o     sticky: the current block saturated
//   count_o        products accepted in the current block
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4,
  localparam int CW       = count_width(BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  input  logic              clear_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_valid_o,
  input  logic              acc_ready_i,
  output logic              overflow_o,
  output logic [CW-1:0]     count_o
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             beat;
  logic             last_beat;
  logic             result_taken;

  mult_sat_adder #(
    .ACC_W (ACC_W),
    .B_W   (PROD_W)
  ) u_sat_adder (
    .a        (acc_q),
    .b        (prod_i),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  assign beat         = prod_valid_i & prod_ready_o;
  assign last_beat    = beat && (count_q == CW'(BLOCK_LEN - 1));
  assign result_taken = (state_q == HOLD) && acc_ready_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    prod_ready_o = 1'b0;
    acc_valid_o  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        prod_ready_o = 1'b1;
        if (last_beat) state_d = HOLD;
      end
      HOLD: begin
        acc_valid_o = 1'b1;
        if (acc_ready_i) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    // An abort overrides both a completing beat and a pending result.
    if (clear_i) state_d = ACCUM;
  end

  // Datapath. In HOLD no beat can occur (prod_ready_o is low), so the sum,
  // count and overflow flag stay frozen until the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i || result_taken) begin
      acc_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (beat) begin
      acc_q      <= add_sum;
      count_q    <= count_q + CW'(1);
      overflow_q <= overflow_q | add_ovf;
    end
  end

  assign acc_o      = acc_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
module tb_mult_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default parameters (ACC_W=16, BLOCK_LEN=4)
  logic [7:0]  pa;  logic va, ra, ca, ava, ara, oa;
  logic [15:0] aa;  logic [2:0] na;
  // Instance B: ACC_W=9, BLOCK_LEN=4
  logic [7:0]  pb;  logic vb, rb, cb, avb, arb, ob;
  logic [8:0]  ab;  logic [2:0] nb;
  // Instance C: BLOCK_LEN=1
  logic [7:0]  pc;  logic vc, rc, cc, avc, arc, oc;
  logic [15:0] ac;  logic [0:0] nc;

  mult_product_accumulator #(.PROD_W(8), .ACC_W(16), .BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .prod_i(pa), .prod_valid_i(va), .prod_ready_o(ra),
    .clear_i(ca), .acc_o(aa), .acc_valid_o(ava), .acc_ready_i(ara),
    .overflow_o(oa), .count_o(na));

  mult_product_accumulator #(.PROD_W(8), .ACC_W(9), .BLOCK_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod_i(pb), .prod_valid_i(vb), .prod_ready_o(rb),
    .clear_i(cb), .acc_o(ab), .acc_valid_o(avb), .acc_ready_i(arb),
    .overflow_o(ob), .count_o(nb));

  mult_product_accumulator #(.PROD_W(8), .ACC_W(16), .BLOCK_LEN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .prod_i(pc), .prod_valid_i(vc), .prod_ready_o(rc),
    .clear_i(cc), .acc_o(ac), .acc_valid_o(avc), .acc_ready_i(arc),
    .overflow_o(oc), .count_o(nc));

  // Expected results, pushed when the last beat of a block is driven.
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] q_c[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set before this call are sampled at the edge,
  // outputs are stable on return.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitors: a handshake seen on the negedge completes on the next
  // posedge, so each result is popped and compared exactly once.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ava && ara) begin
        check("sb_a_nonempty", 32'(q_a.size() > 0), 32'd1);
        if (q_a.size() > 0) check("sb_a_result", 32'(aa), q_a.pop_front());
      end
      if (avb && arb) begin
        check("sb_b_nonempty", 32'(q_b.size() > 0), 32'd1);
        if (q_b.size() > 0) check("sb_b_result", 32'(ab), q_b.pop_front());
      end
      if (avc && arc) begin
        check("sb_c_nonempty", 32'(q_c.size() > 0), 32'd1);
        if (q_c.size() > 0) check("sb_c_result", 32'(ac), q_c.pop_front());
      end
    end
  end

  initial begin
    pa = '0; va = 0; ca = 0; ara = 0;
    pb = '0; vb = 0; cb = 0; arb = 0;
    pc = '0; vc = 0; cc = 0; arc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_acc",   32'(aa),  32'd0);
    check("rst_count", 32'(na),  32'd0);
    check("rst_valid", 32'(ava), 32'd0);
    check("rst_ovf",   32'(oa),  32'd0);
    check("rst_ready", 32'(ra),  32'd1);

    // 1: four back-to-back 225s, consumer always ready
    ara = 1; pa = 8'd225; va = 1;
    q_a.push_back(32'd900);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t1_count", 32'(na), 32'(i));
    end
    va = 0;
    check("t1_acc",   32'(aa),  32'd900);
    check("t1_valid", 32'(ava), 32'd1);
    check("t1_ovf",   32'(oa),  32'd0);
    check("t1_ready_hold", 32'(ra), 32'd0);
    tick();
    check("t1_valid_1cyc", 32'(ava), 32'd0);
    check("t1_count_clr",  32'(na),  32'd0);
    check("t1_acc_clr",    32'(aa),  32'd0);

    // 2: products 1..4, consumer stalls, extra product offered in HOLD
    ara = 0;
    q_a.push_back(32'd10);
    for (int i = 1; i <= 4; i++) begin
      pa = 8'(i); va = 1;
      tick();
    end
    pa = 8'd50; va = 1;
    for (int i = 0; i < 5; i++) begin
      check("t2_acc_held", 32'(aa),  32'd10);
      check("t2_ready0",   32'(ra),  32'd0);
      check("t2_valid",    32'(ava), 32'd1);
      check("t2_count",    32'(na),  32'd4);
      tick();
    end
    va = 0; ara = 1;
    tick();
    check("t2_released", 32'(ava), 32'd0);
    check("t2_acc_clr",  32'(aa),  32'd0);

    // 3: ACC_W=9 saturation, overflow sticky until accepted
    arb = 0; vb = 1;
    pb = 8'd225; tick();
    check("t3_acc1", 32'(ab), 32'd225);
    tick();
    check("t3_acc2", 32'(ab), 32'd450);
    check("t3_ovf2", 32'(ob), 32'd0);
    tick();
    check("t3_acc3", 32'(ab), 32'd511);
    check("t3_ovf3", 32'(ob), 32'd1);
    pb = 8'd0;
    q_b.push_back(32'd511);
    tick();
    vb = 0;
    check("t3_acc4",   32'(ab),  32'd511);
    check("t3_valid4", 32'(avb), 32'd1);
    tick();
    check("t3_ovf_hold", 32'(ob), 32'd1);
    arb = 1;
    tick();
    check("t3_ovf_clr", 32'(ob),  32'd0);
    check("t3_acc_clr", 32'(ab),  32'd0);
    check("t3_valid0",  32'(avb), 32'd0);

    // 4: clear after two beats, with a beat offered in the same cycle
    ara = 0;
    pa = 8'd7; va = 1; tick();
    pa = 8'd9; tick();
    check("t4_partial", 32'(aa), 32'd16);
    check("t4_count2",  32'(na), 32'd2);
    pa = 8'd5; ca = 1;
    tick();
    ca = 0;
    check("t4_clr_acc",   32'(aa), 32'd0);
    check("t4_clr_count", 32'(na), 32'd0);
    check("t4_clr_ready", 32'(ra), 32'd1);
    pa = 8'd1;
    q_a.push_back(32'd4);
    repeat (4) tick();
    va = 0;
    check("t4_acc", 32'(aa), 32'd4);
    ara = 1;
    tick();

    // 5: asynchronous reset mid-block, no clock edge in between
    ara = 0; pa = 8'd2; va = 1;
    repeat (3) tick();
    va = 0;
    check("t5_count3", 32'(na), 32'd3);
    #1;
    rst_n = 0;
    #1;
    check("t5_arst_acc",   32'(aa),  32'd0);
    check("t5_arst_count", 32'(na),  32'd0);
    check("t5_arst_valid", 32'(ava), 32'd0);
    check("t5_arst_ovf",   32'(oa),  32'd0);
    tick();
    rst_n = 1;
    tick();
    check("t5_ready", 32'(ra), 32'd1);
    q_a.push_back(32'd8);
    va = 1;
    repeat (4) tick();
    va = 0;
    check("t5_acc", 32'(aa), 32'd8);
    ara = 1;
    tick();

    // 6: BLOCK_LEN=1 with random handshakes on both sides
    for (int i = 0; i < 300; i++) begin
      vc  = 1'($urandom_range(0, 1));
      arc = 1'($urandom_range(0, 1));
      pc  = 8'($urandom_range(0, 255));
      if (vc && rc) q_c.push_back(32'(pc));
      tick();
    end
    vc = 0; arc = 1;
    repeat (4) tick();

    check("sb_a_drained", 32'(q_a.size()), 32'd0);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);
    check("sb_c_drained", 32'(q_c.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
